// File: rtl/rs_erasure_collector.sv
`default_nettype none
// ============================================================================
// Module  : rs_erasure_collector
// Desc    : Assembles one RS codeword plus erasure flags, then streams it to the
//           decoder. Define ERASURE_POS_LIST_EN to build the erasure position list.
// Rev     : 1.0  initial release
// ============================================================================
module rs_erasure_collector #(
  parameter int N_SYM    = 255,
  parameter int MAX_ERAS = 16,
  parameter int POS_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             new_channel_char,
  input  logic [7:0]       recieved_codeword,
  input  logic             erasure_flag_0,
  input  logic             erasure_flag_1,
  input  logic             erasure_flag_2,
  input  logic [1:0]       thr_sel,
  output logic             send_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_sym,
  output logic             out_erased,
  output logic             out_last,
  output logic [4:0]       era_count,
  output logic             era_overflow,
  output logic             sym_dropped,
  input  logic [3:0]       era_rd_idx,
  output logic [POS_W-1:0] era_rd_pos
);

  localparam logic [0:0]       S_COLLECT = 1'b0;
  localparam logic [0:0]       S_STREAM  = 1'b1;
  localparam logic [POS_W-1:0] LAST_IDX  = POS_W'(N_SYM - 1);
  localparam logic [4:0]       ERA_MAX   = 5'(MAX_ERAS);

  logic [0:0]       state_q, state_d;
  logic             nc_q, nc_d;
  logic [POS_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_nxt;
  logic [1:0]       thr_q, thr_d, thr_eff;
  logic [4:0]       era_count_q, era_count_d;
  logic             era_ovf_q, era_ovf_d, drop_q, drop_d;
  logic             send_q, send_d, valid_q, valid_d;
  logic [7:0]       sym_q, sym_d;
  logic             erased_q, erased_d, last_q, last_d;
  logic             sym_strobe, sel_flag, mem_we, pos_we;

  logic [7:0] mem_q     [N_SYM];
  logic       era_bit_q [N_SYM];

  assign sym_strobe = new_channel_char & ~nc_q;
  assign nc_d       = new_channel_char;
  assign rd_nxt     = (rd_ptr_q == LAST_IDX) ? '0 : rd_ptr_q + POS_W'(1);

  // The threshold for symbol 0 comes straight from the port; later symbols use the latched copy.
  always_comb begin
    thr_eff = (wr_ptr_q == '0) ? thr_sel : thr_q;
    case (thr_eff)
      2'd0:    sel_flag = erasure_flag_0;
      2'd1:    sel_flag = erasure_flag_1;
      2'd2:    sel_flag = erasure_flag_2;
      default: sel_flag = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    thr_d       = thr_q;
    era_count_d = era_count_q;
    era_ovf_d   = era_ovf_q;
    drop_d      = drop_q;
    send_d      = send_q;
    valid_d     = valid_q;
    sym_d       = sym_q;
    erased_d    = erased_q;
    last_d      = last_q;
    mem_we      = 1'b0;
    pos_we      = 1'b0;
    case (state_q)
      S_COLLECT: begin
        if (sym_strobe) begin
          mem_we = 1'b1;
          if (wr_ptr_q == '0) thr_d = thr_sel;
          if (sel_flag) begin
            if (era_count_q < ERA_MAX) begin
              pos_we      = 1'b1;
              era_count_d = era_count_q + 5'd1;
            end else begin
              era_ovf_d = 1'b1;
            end
          end
          if (wr_ptr_q == LAST_IDX) begin
            // Prefetch symbol 0 so the stream starts without a bubble.
            wr_ptr_d = '0;
            state_d  = S_STREAM;
            send_d   = 1'b1;
            valid_d  = 1'b1;
            rd_ptr_d = '0;
            sym_d    = mem_q[0];
            erased_d = era_bit_q[0] & ~era_ovf_d;
            last_d   = 1'b0;
          end else begin
            wr_ptr_d = wr_ptr_q + POS_W'(1);
          end
        end
      end
      default: begin
        if (sym_strobe) drop_d = 1'b1;
        if (valid_q && out_ready) begin
          if (last_q) begin
            state_d     = S_COLLECT;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            era_count_d = '0;
            era_ovf_d   = 1'b0;
            drop_d      = 1'b0;
            send_d      = 1'b0;
            valid_d     = 1'b0;
            sym_d       = '0;
            erased_d    = 1'b0;
            last_d      = 1'b0;
          end else begin
            rd_ptr_d = rd_nxt;
            sym_d    = mem_q[rd_nxt];
            erased_d = era_bit_q[rd_nxt] & ~era_ovf_q;
            last_d   = (rd_nxt == LAST_IDX);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_COLLECT;
      nc_q        <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      thr_q       <= '0;
      era_count_q <= '0;
      era_ovf_q   <= 1'b0;
      drop_q      <= 1'b0;
      send_q      <= 1'b0;
      valid_q     <= 1'b0;
      sym_q       <= '0;
      erased_q    <= 1'b0;
      last_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      nc_q        <= nc_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      thr_q       <= thr_d;
      era_count_q <= era_count_d;
      era_ovf_q   <= era_ovf_d;
      drop_q      <= drop_d;
      send_q      <= send_d;
      valid_q     <= valid_d;
      sym_q       <= sym_d;
      erased_q    <= erased_d;
      last_q      <= last_d;
    end
  end

  // Frame storage needs no reset: every entry is rewritten before it is read.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[wr_ptr_q]     <= recieved_codeword;
      era_bit_q[wr_ptr_q] <= sel_flag;
    end
  end

`ifdef ERASURE_POS_LIST_EN
  localparam int EIDX_W = $clog2(MAX_ERAS);
  logic [POS_W-1:0] pos_q [MAX_ERAS];
  logic [POS_W-1:0] era_rd_pos_q, era_rd_pos_d;

  always_ff @(posedge clk) begin
    if (pos_we) pos_q[era_count_q[EIDX_W-1:0]] <= wr_ptr_q;
  end

  assign era_rd_pos_d = ({1'b0, era_rd_idx} < era_count_q) ? pos_q[era_rd_idx] : '0;

  always_ff @(posedge clk) begin
    if (reset) era_rd_pos_q <= '0;
    else       era_rd_pos_q <= era_rd_pos_d;
  end

  assign era_rd_pos = era_rd_pos_q;
`else
  logic unused_pos_sigs;
  assign unused_pos_sigs = ^{era_rd_idx, pos_we};
  assign era_rd_pos      = '0;
`endif

  assign send_data    = send_q;
  assign out_valid    = valid_q;
  assign out_sym      = sym_q;
  assign out_erased   = erased_q;
  assign out_last     = last_q;
  assign era_count    = era_count_q;
  assign era_overflow = era_ovf_q;
  assign sym_dropped  = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_rs_erasure_collector.sv
`default_nettype none
// Testbench for rs_erasure_collector: table of directed frames, randomized frames,
// and hand-written reset/drop sequences, all checked against a frame-level model.
module tb_rs_erasure_collector;
  localparam int N  = 255;
  localparam int ME = 16;

  logic       clk = 1'b0;
  logic       reset, ncc, f0, f1, f2, out_ready;
  logic [7:0] rx;
  logic [1:0] thr_sel;
  logic       send_data, out_valid, out_erased, out_last, era_overflow, sym_dropped;
  logic [7:0] out_sym, era_rd_pos;
  logic [4:0] era_count;
  logic [3:0] era_rd_idx;

  always #5 clk = ~clk;

  rs_erasure_collector dut (
    .clk(clk), .reset(reset), .new_channel_char(ncc), .recieved_codeword(rx),
    .erasure_flag_0(f0), .erasure_flag_1(f1), .erasure_flag_2(f2), .thr_sel(thr_sel),
    .send_data(send_data), .out_valid(out_valid), .out_ready(out_ready), .out_sym(out_sym),
    .out_erased(out_erased), .out_last(out_last), .era_count(era_count),
    .era_overflow(era_overflow), .sym_dropped(sym_dropped), .era_rd_idx(era_rd_idx),
    .era_rd_pos(era_rd_pos)
  );

  int n_pass = 0, n_total = 0, cur_row = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL row%0d %s: got %0d expected %0d", cur_row, name, act, exp);
  endtask

  // Frame contents and model results
  logic [7:0] fb [N];
  bit fl0 [N], fl1 [N], fl2 [N];
  bit m_era [N];
  int m_pos [$];
  int m_cnt;
  bit m_ovf;

  task automatic model(input int thr);
    m_pos.delete();
    for (int i = 0; i < N; i++) begin
      bit f;
      f = (thr == 0) ? fl0[i] : (thr == 1) ? fl1[i] : (thr == 2) ? fl2[i] : 1'b0;
      m_era[i] = f;
      if (f) m_pos.push_back(i);
    end
    m_ovf = (m_pos.size() > ME);
    m_cnt = m_ovf ? ME : m_pos.size();
    for (int i = 0; i < N; i++) m_era[i] = m_era[i] & !m_ovf;
  endtask

  typedef struct {
    int thr;        // thr_sel at frame start
    int flag_mode;  // 0: flag_0 at 3,100,254  1: flag_0 at 0..19  2: all flags  3: random
    int byte_mode;  // 0: byte = index  1: random bytes
    int hold;       // cycles new_channel_char stays high per symbol
    int ready_mode; // 0: always  1: 1,0,0,1 pattern  2: random
    int mid_thr;    // thr_sel value driven at symbol 128, -1 = unchanged
    bit drop_mid;   // pulse new_channel_char during the stream
    bit drop_last;  // pulse new_channel_char with the final handshake
    int exp_cnt;    // expected era_count, -1 = model only
    int exp_ovf;
  } rec_t;

  task automatic build(input rec_t r);
    int pct;
    pct = 2 + 3 * $urandom_range(0, 2);
    for (int i = 0; i < N; i++) begin
      fb[i] = (r.byte_mode == 0) ? 8'(i) : 8'($urandom);
      case (r.flag_mode)
        0: begin fl0[i] = (i == 3 || i == 100 || i == 254); fl1[i] = 0; fl2[i] = 0; end
        1: begin fl0[i] = (i < 20); fl1[i] = 0; fl2[i] = 0; end
        2: begin fl0[i] = 1; fl1[i] = 1; fl2[i] = 1; end
        default: begin
          fl0[i] = ($urandom_range(0, 99) < pct);
          fl1[i] = ($urandom_range(0, 99) < pct);
          fl2[i] = ($urandom_range(0, 99) < pct);
        end
      endcase
    end
    model(r.thr);
  endtask

  task automatic send_syms(input int count, input int hold, input int thr, input int mid_thr);
    thr_sel = 2'(thr);
    for (int i = 0; i < count; i++) begin
      @(negedge clk);
      if (i == 128 && mid_thr >= 0) thr_sel = 2'(mid_thr);
      rx = fb[i]; f0 = fl0[i]; f1 = fl1[i]; f2 = fl2[i];
      ncc = 1'b1;
      if (i == N - 1) chk("send_data before last", send_data, 0);
      @(negedge clk);
      if (i == N - 1) chk("send_data after last", send_data, 1);
      repeat (hold - 1) @(negedge clk);
      ncc = 1'b0;
    end
  endtask

  task automatic run_frame(input rec_t r);
    int idx, cyc;
    bit rdy, pulsed, drop_exp;
    build(r);
    out_ready = 1'b0;
    send_syms(N, r.hold, r.thr, r.mid_thr);
    chk("era_count", era_count, m_cnt);
    chk("era_overflow", era_overflow, m_ovf);
    if (r.exp_cnt >= 0) begin
      chk("era_count table", era_count, r.exp_cnt);
      chk("era_overflow table", era_overflow, r.exp_ovf);
    end
    chk("sym_dropped start", sym_dropped, 0);
    for (int k = 0; k < ME; k++) begin
      era_rd_idx = 4'(k);
      @(negedge clk);
`ifdef ERASURE_POS_LIST_EN
      chk("era_rd_pos", era_rd_pos, (k < m_cnt) ? m_pos[k] : 0);
`else
      chk("era_rd_pos", era_rd_pos, 0);
`endif
    end
    idx = 0; cyc = 0; pulsed = 0; drop_exp = 0;
    while (idx < N && cyc < 4000) begin
      chk("out_valid", out_valid, 1);
      chk("send_data", send_data, 1);
      chk("out_sym", out_sym, fb[idx]);
      chk("out_erased", out_erased, m_era[idx]);
      chk("out_last", out_last, (idx == N - 1));
      chk("era_count stable", era_count, m_cnt);
      chk("sym_dropped", sym_dropped, drop_exp);
      case (r.ready_mode)
        0:       rdy = 1;
        1:       rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: rdy = $urandom_range(0, 1);
      endcase
      out_ready = rdy;
      if (ncc) ncc = 1'b0;
      else if (r.drop_mid && idx == 10 && !pulsed) begin ncc = 1'b1; pulsed = 1; end
      else if (r.drop_last && idx == N - 1 && rdy) ncc = 1'b1;
      @(negedge clk);
      cyc++;
      if (rdy) idx++;
      drop_exp = pulsed;
    end
    if (idx < N) chk("stream timeout", idx, N);
    ncc = 1'b0;
    out_ready = 1'b0;
    chk("out_valid after", out_valid, 0);
    chk("send_data after", send_data, 0);
    chk("era_count after", era_count, 0);
    chk("era_overflow after", era_overflow, 0);
    chk("sym_dropped after", sym_dropped, 0);
  endtask

  task automatic chk_reset_state();
    chk("rst send_data", send_data, 0);
    chk("rst out_valid", out_valid, 0);
    chk("rst out_sym", out_sym, 0);
    chk("rst out_erased", out_erased, 0);
    chk("rst out_last", out_last, 0);
    chk("rst era_count", era_count, 0);
    chk("rst era_overflow", era_overflow, 0);
    chk("rst sym_dropped", sym_dropped, 0);
    chk("rst era_rd_pos", era_rd_pos, 0);
  endtask

  rec_t tbl [9];
  rec_t rr;

  initial begin
    reset = 1'b1; ncc = 0; rx = 0; f0 = 0; f1 = 0; f2 = 0; thr_sel = 0;
    out_ready = 0; era_rd_idx = 0;
    tbl[0] = '{0, 0, 0, 1, 0, -1, 0, 0, 3, 0};
    tbl[1] = '{0, 1, 0, 1, 0, -1, 0, 0, 16, 1};
    tbl[2] = '{0, 0, 1, 4, 0, -1, 0, 0, 3, 0};
    tbl[3] = '{0, 0, 1, 1, 1, -1, 1, 0, 3, 0};
    tbl[4] = '{3, 2, 1, 1, 0, 1, 0, 0, 0, 0};
    tbl[5] = '{1, 2, 1, 1, 2, -1, 0, 1, 16, 1};
    tbl[6] = '{2, 3, 1, 2, 2, -1, 0, 0, -1, -1};
    tbl[7] = '{1, 3, 1, 1, 2, -1, 1, 1, -1, -1};
    tbl[8] = '{0, 3, 0, 3, 1, -1, 0, 0, -1, -1};
    repeat (3) @(negedge clk);
    chk_reset_state();
    reset = 1'b0;

    for (int i = 0; i < 9; i++) begin
      cur_row = i;
      run_frame(tbl[i]);
    end

    // Reset in the middle of collection, then a fresh frame must start at index 0.
    cur_row = 100;
    rr = '{0, 3, 1, 1, 0, -1, 0, 0, -1, -1};
    build(rr);
    send_syms(130, 1, 0, -1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk_reset_state();
    reset = 1'b0;
    run_frame(tbl[0]);

    for (int i = 0; i < 4; i++) begin
      cur_row = 200 + i;
      rr = '{int'($urandom_range(0, 3)), 3, 1, int'($urandom_range(1, 3)), 2, -1, 0, 0, -1, -1};
      run_frame(rr);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
